// File: rtl/audio_pkg.sv
// Shared encodings and defaults for the codec sample buffer slice.
// Holds fill/request FSM state types, default sample geometry and small helpers.
package audio_pkg;

   localparam int AUDIO_WIDTH = 16;
   localparam int AUDIO_DEPTH = 8;

   typedef enum logic {
      FILL_PRIME = 1'b0,
      FILL_RUN   = 1'b1
   } fill_state_t;

   typedef enum logic {
      REQ_IDLE = 1'b0,
      REQ_WAIT = 1'b1
   } req_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

endpackage

// File: rtl/codec_sample_buffer_if.sv
// Sample/frame handshake between music player, buffer and AC97 codec.
// master = player/codec side, slave = the buffer.
interface codec_sample_buffer_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic signed [WIDTH-1:0] sample_in;
   logic                    sample_in_valid;
   logic                    new_frame;
   logic                    sample_request;
   logic signed [WIDTH-1:0] sample_out;
   logic [LW-1:0]           level;
   logic [7:0]              underflow_count;
   logic                    overflow;

   modport master (
      output sample_in, sample_in_valid, new_frame,
      input  sample_request, sample_out, level, underflow_count, overflow
   );

   modport slave (
      input  sample_in, sample_in_valid, new_frame,
      output sample_request, sample_out, level, underflow_count, overflow
   );
endinterface

// File: rtl/sample_fifo.sv
// Sample storage with wrap-around read/write pointers; occupancy is tracked by the owner.
// o_head presents the entry at the read pointer combinationally.
module sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic signed [WIDTH-1:0] i_data,
   output logic signed [WIDTH-1:0] o_head
);
   localparam int PW = $clog2(DEPTH);

   logic signed [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]           r_wr_ptr;
   logic [PW-1:0]           r_rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1'b1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1'b1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/codec_sample_buffer.sv
// Elastic sample buffer between the music player and the AC97 codec interface:
// primes to half full, then serves one sample per codec frame and re-requests refills.
module codec_sample_buffer
   import audio_pkg::*;
#(
   parameter int WIDTH       = AUDIO_WIDTH,
   parameter int DEPTH       = AUDIO_DEPTH,
   parameter int REQ_TIMEOUT = 1024
) (
   input logic                  clk,
   input logic                  reset,
   codec_sample_buffer_if.slave bus
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(REQ_TIMEOUT + 1);

   logic                    w_push;
   logic                    w_pop;
   logic                    w_underflow;
   logic                    w_room;
   logic signed [WIDTH-1:0] w_head;

   fill_state_t             r_fill_state;
   req_state_t              r_req_state;
   logic [LW-1:0]           r_level;
   logic signed [WIDTH-1:0] r_sample_out;
   logic [7:0]              r_underflow_count;
   logic                    r_overflow;
   logic                    r_sample_request;
   logic [TW-1:0]           r_timer;

   // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
   always_comb begin
      w_pop       = 1'b0;
      w_underflow = 1'b0;
      if (r_fill_state == FILL_RUN && bus.new_frame) begin
         if (r_level != {LW{1'b0}}) begin
            w_pop = 1'b1;
         end else begin
            w_underflow = 1'b1;
         end
      end else begin
         w_pop       = 1'b0;
         w_underflow = 1'b0;
      end
      w_push = bus.sample_in_valid && ((r_level < LW'(DEPTH)) || w_pop);
      w_room = (r_level + LW'(w_push)) < LW'(DEPTH);
   end

   sample_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (w_push),
      .i_pop  (w_pop),
      .i_data (bus.sample_in),
      .o_head (w_head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_level           <= {LW{1'b0}};
         r_sample_out      <= {WIDTH{1'b0}};
         r_underflow_count <= 8'd0;
         r_overflow        <= 1'b0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1'b1);
            2'b01:   r_level <= r_level - LW'(1'b1);
            default: r_level <= r_level;
         endcase
         if (w_pop) begin
            r_sample_out <= w_head;
         end
         if (w_underflow) begin
            r_underflow_count <= sat_inc8(r_underflow_count);
         end
         if (bus.sample_in_valid && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Fill and request FSMs; RUN is terminal until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fill_state     <= FILL_PRIME;
         r_req_state      <= REQ_IDLE;
         r_sample_request <= 1'b0;
         r_timer          <= {TW{1'b0}};
      end else begin
         case (r_fill_state)
            FILL_PRIME: r_fill_state <= (r_level >= LW'(DEPTH / 2)) ? FILL_RUN : FILL_PRIME;
            FILL_RUN:   r_fill_state <= FILL_RUN;
            default:    r_fill_state <= FILL_PRIME;
         endcase

         case (r_req_state)
            REQ_IDLE: begin
               r_timer <= {TW{1'b0}};
               if (w_room) begin
                  r_sample_request <= 1'b1;
                  r_req_state      <= REQ_WAIT;
               end else begin
                  r_sample_request <= 1'b0;
               end
            end
            REQ_WAIT: begin
               r_sample_request <= 1'b0;
               if (bus.sample_in_valid || r_timer == TW'(REQ_TIMEOUT - 1)) begin
                  r_req_state <= REQ_IDLE;
                  r_timer     <= {TW{1'b0}};
               end else begin
                  r_timer <= r_timer + TW'(1'b1);
               end
            end
            default: begin
               r_req_state      <= REQ_IDLE;
               r_sample_request <= 1'b0;
               r_timer          <= {TW{1'b0}};
            end
         endcase
      end
   end

   assign bus.sample_request  = r_sample_request;
   assign bus.sample_out      = r_sample_out;
   assign bus.level           = r_level;
   assign bus.underflow_count = r_underflow_count;
   assign bus.overflow        = r_overflow;

endmodule

// File: tb/tb_codec_sample_buffer.sv
// Directed bench for codec_sample_buffer: priming, draining, underflow saturation,
// overflow, request timeout and mid-operation reset.
module tb_codec_sample_buffer;
   import audio_pkg::*;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   codec_sample_buffer_if #(.WIDTH(16), .DEPTH(8)) bus ();

   codec_sample_buffer #(
      .WIDTH       (16),
      .DEPTH       (8),
      .REQ_TIMEOUT (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want finish before it");
      $fatal(1);
   end

   task automatic pulse_valid(input logic signed [15:0] v);
      bus.sample_in       = v;
      bus.sample_in_valid = 1'b1;
      @(negedge clk);
      bus.sample_in_valid = 1'b0;
   endtask

   task automatic pulse_frame();
      bus.new_frame = 1'b1;
      @(negedge clk);
      bus.new_frame = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.sample_request === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.level !== 4'd0 || bus.sample_out !== 16'sd0 || bus.sample_request !== 1'b0 ||
          bus.underflow_count !== 8'd0 || bus.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got level=%0d out=%0d req=%b uf=%0d ov=%b want all zero",
                  bus.level, bus.sample_out, bus.sample_request, bus.underflow_count, bus.overflow);
      end
      reset = 1'b0;
      // PRIME ignores frames
      pulse_frame();
      n_cmp++;
      if (bus.underflow_count !== 8'd0 || bus.sample_out !== 16'sd0 || bus.level !== 4'd0) begin
         n_err++;
         $display("FAIL prime_ignore: got uf=%0d out=%0d level=%0d want 0/0/0",
                  bus.underflow_count, bus.sample_out, bus.level);
      end
   endtask

   task automatic test_prime_fill();
      bit ok;
      for (int k = 1; k <= 4; k++) begin
         wait_req(ok);
         n_cmp++;
         if (!ok) begin
            n_err++;
            $display("FAIL prime_req_%0d: got no request within 100 cycles, want one", k);
         end
         repeat (2) @(negedge clk);
         pulse_valid(16'(k));
      end
      n_cmp++;
      if (bus.level !== 4'd4 || dut.r_fill_state !== FILL_PRIME) begin
         n_err++;
         $display("FAIL prime_level4: got level=%0d state=%0d want 4/PRIME", bus.level, dut.r_fill_state);
      end
      @(negedge clk);
      n_cmp++;
      if (dut.r_fill_state !== FILL_RUN || bus.underflow_count !== 8'd0) begin
         n_err++;
         $display("FAIL prime_run: got state=%0d uf=%0d want RUN/0", dut.r_fill_state, bus.underflow_count);
      end
   endtask

   task automatic test_drain();
      for (int k = 1; k <= 4; k++) begin
         n_cmp++;
         if (bus.sample_out !== 16'(k - 1)) begin
            n_err++;
            $display("FAIL drain_before_%0d: got %0d want %0d", k, bus.sample_out, k - 1);
         end
         pulse_frame();
         n_cmp++;
         if (bus.sample_out !== 16'(k) || bus.level !== 4'(4 - k)) begin
            n_err++;
            $display("FAIL drain_pop_%0d: got out=%0d level=%0d want %0d/%0d",
                     k, bus.sample_out, bus.level, k, 4 - k);
         end
         repeat (9) @(negedge clk);
      end
   endtask

   task automatic test_underflow();
      for (int i = 0; i < 300; i++) begin
         pulse_frame();
         if (i == 99) begin
            n_cmp++;
            if (bus.underflow_count !== 8'd100) begin
               n_err++;
               $display("FAIL underflow_100: got %0d want 100", bus.underflow_count);
            end
         end
      end
      n_cmp++;
      if (bus.underflow_count !== 8'd255 || bus.sample_out !== 16'sd4 || bus.level !== 4'd0) begin
         n_err++;
         $display("FAIL underflow_sat: got uf=%0d out=%0d level=%0d want 255/4/0",
                  bus.underflow_count, bus.sample_out, bus.level);
      end
   endtask

   task automatic test_overflow();
      logic signed [15:0] exp_v;
      for (int k = 0; k < 8; k++) begin
         pulse_valid(16'(10 + k));
      end
      n_cmp++;
      if (bus.level !== 4'd8 || bus.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL full_level: got level=%0d ov=%b want 8/0", bus.level, bus.overflow);
      end
      pulse_valid(16'sd99);
      n_cmp++;
      if (bus.level !== 4'd8 || bus.overflow !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_drop: got level=%0d ov=%b want 8/1", bus.level, bus.overflow);
      end
      bus.sample_in       = 16'sd20;
      bus.sample_in_valid = 1'b1;
      bus.new_frame       = 1'b1;
      @(negedge clk);
      bus.sample_in_valid = 1'b0;
      bus.new_frame       = 1'b0;
      n_cmp++;
      if (bus.level !== 4'd8 || bus.sample_out !== 16'sd10) begin
         n_err++;
         $display("FAIL full_push_pop: got level=%0d out=%0d want 8/10", bus.level, bus.sample_out);
      end
      for (int k = 0; k < 8; k++) begin
         exp_v = (k < 7) ? 16'(11 + k) : 16'sd20;
         pulse_frame();
         n_cmp++;
         if (bus.sample_out !== exp_v) begin
            n_err++;
            $display("FAIL wrap_pop_%0d: got %0d want %0d", k, bus.sample_out, exp_v);
         end
      end
      n_cmp++;
      if (bus.level !== 4'd0) begin
         n_err++;
         $display("FAIL wrap_empty: got level=%0d want 0", bus.level);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int cnt;
      bit found;
      wait_req(ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL timeout_sync: got no request within 100 cycles, want one");
      end
      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.sample_request !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_width_%0d: got req=%b one cycle after pulse, want 0", p, bus.sample_request);
         end
         cnt   = 1;
         found = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if (bus.sample_request === 1'b1) begin
               found = 1'b1;
               break;
            end
         end
         n_cmp++;
         if (!found || cnt != 17) begin
            n_err++;
            $display("FAIL timeout_period_%0d: got found=%b period=%0d want 1/17", p, found, cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      for (int k = 0; k < 5; k++) begin
         pulse_valid(16'(30 + k));
      end
      wait_req(ok);
      n_cmp++;
      if (!ok || bus.level !== 4'd5 || dut.r_req_state !== REQ_WAIT) begin
         n_err++;
         $display("FAIL midreset_setup: got ok=%b level=%0d rstate=%0d want 1/5/WAIT",
                  ok, bus.level, dut.r_req_state);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if (bus.level !== 4'd0 || bus.sample_out !== 16'sd0 || bus.sample_request !== 1'b0 ||
          bus.overflow !== 1'b0 || bus.underflow_count !== 8'd0 ||
          dut.r_fill_state !== FILL_PRIME || dut.r_req_state !== REQ_IDLE) begin
         n_err++;
         $display("FAIL midreset_clear: got level=%0d out=%0d req=%b ov=%b uf=%0d fs=%0d rs=%0d want 0/0/0/0/0/PRIME/IDLE",
                  bus.level, bus.sample_out, bus.sample_request, bus.overflow, bus.underflow_count,
                  dut.r_fill_state, dut.r_req_state);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.sample_request !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_req: got req=%b want 1", bus.sample_request);
      end
   endtask

   task automatic test_empty_push_pop();
      for (int k = 0; k < 4; k++) begin
         pulse_valid(16'(40 + k));
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         pulse_frame();
      end
      n_cmp++;
      if (bus.sample_out !== 16'sd43 || bus.level !== 4'd0) begin
         n_err++;
         $display("FAIL refill_drain: got out=%0d level=%0d want 43/0", bus.sample_out, bus.level);
      end
      bus.sample_in       = 16'sd77;
      bus.sample_in_valid = 1'b1;
      bus.new_frame       = 1'b1;
      @(negedge clk);
      bus.sample_in_valid = 1'b0;
      bus.new_frame       = 1'b0;
      n_cmp++;
      if (bus.underflow_count !== 8'd1 || bus.level !== 4'd1 || bus.sample_out !== 16'sd43) begin
         n_err++;
         $display("FAIL empty_push_pop: got uf=%0d level=%0d out=%0d want 1/1/43",
                  bus.underflow_count, bus.level, bus.sample_out);
      end
      pulse_frame();
      n_cmp++;
      if (bus.sample_out !== 16'sd77 || bus.level !== 4'd0 || bus.underflow_count !== 8'd1) begin
         n_err++;
         $display("FAIL empty_stored: got out=%0d level=%0d uf=%0d want 77/0/1",
                  bus.sample_out, bus.level, bus.underflow_count);
      end
   endtask

   initial begin
      n_cmp               = 0;
      n_err               = 0;
      reset               = 1'b1;
      bus.sample_in       = 16'sd0;
      bus.sample_in_valid = 1'b0;
      bus.new_frame       = 1'b0;
      test_reset();
      test_prime_fill();
      test_drain();
      test_underflow();
      test_overflow();
      test_timeout();
      test_reset_mid();
      test_empty_push_pop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
